// File: rtl/pipe_pkg.sv
// Shared definitions for the issue stage: opcode values, instruction field
// positions, the default register count, FSM states and the legality decode.
package pipe_pkg;

  localparam int NREG_DEF = 8;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 4;
  localparam int RT_MSB  = 3;
  localparam int RT_LSB  = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Unknown opcodes and any register field the opcode actually reads or
  // writes that points outside R0..R7 make the instruction illegal.
  function automatic logic instr_illegal(input logic [15:0] instr);
    logic [3:0] op;
    op = instr[OP_MSB:OP_LSB];
    case (op)
      OP_NOP:         return 1'b0;
      OP_LOAD:        return instr[RD_MSB];
      OP_ADD, OP_SUB: return instr[RD_MSB] | instr[RS_MSB] | instr[RT_MSB];
      default:        return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register. The
// writeback clear is visible combinationally on pending_eff so a reader can
// issue in the same cycle its source retires; a same-cycle set wins.
module issue_scoreboard
  import pipe_pkg::*;
#(
  parameter int NREG = NREG_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [3:0]      set_idx,
  input  logic            clr_en,
  input  logic [3:0]      clr_idx,
  output logic [NREG-1:0] pending,
  output logic [NREG-1:0] pending_eff
);

  logic [NREG-1:0] set_mask;
  logic [NREG-1:0] clr_mask;

  // Decode set/clear indices; clears aimed at R8..R15 are dropped.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NREG; i++) begin
      set_mask[i] = set_en && (set_idx == 4'(i));
      clr_mask[i] = clr_en && !clr_idx[3] && (clr_idx == 4'(i));
    end
    pending_eff = pending & ~clr_mask;
  end

  // Pending bits: clear first, then set, so a same-cycle set survives.
  always_ff @(posedge clk) begin
    if (!reset) pending <= '0;
    else        pending <= pending_eff | set_mask;
  end

endmodule

// File: rtl/issue_hazard_ctrl.sv
// In-order issue stage with a one-entry hold register, RAW/WAW hazard check
// against a pending-write scoreboard, illegal-instruction drop and a
// RUN/DRAIN mode. Define ISSUE_STALL_CNT_EN to build the saturating stall
// counter; otherwise stall_cnt is tied to zero and no counter exists.
module issue_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [15:0]      in_instr,
  output logic             in_ready,
  input  logic             wb_valid,
  input  logic [3:0]       wb_rd,
  input  logic             drain_req,
  output logic             issue_valid,
  output logic [3:0]       issue_op,
  output logic [3:0]       issue_rd,
  output logic [3:0]       issue_rs,
  output logic [3:0]       issue_rt,
  output logic [7:0]       issue_imm,
  output logic             stall,
  output logic             drain_done,
  output logic             err_illegal,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e          state, state_nxt;
  logic            hold_vld_p0;
  logic [15:0]     hold_instr_p0;
  logic [3:0]      op, rd, rs, rt;
  logic            illegal, hazard, eval, fire;
  logic [NREG-1:0] pending, pending_eff;
  logic [15:0]     pend16;

  assign op = hold_instr_p0[OP_MSB:OP_LSB];
  assign rd = hold_instr_p0[RD_MSB:RD_LSB];
  assign rs = hold_instr_p0[RS_MSB:RS_LSB];
  assign rt = hold_instr_p0[RT_MSB:RT_LSB];

  // Hazard evaluation of the held instruction against post-writeback state.
  always_comb begin
    pend16  = 16'(pending_eff);
    illegal = instr_illegal(hold_instr_p0);
    case (op)
      OP_LOAD:        hazard = pend16[rd];
      OP_ADD, OP_SUB: hazard = pend16[rd] | pend16[rs] | pend16[rt];
      default:        hazard = 1'b0;
    endcase
  end

  assign eval        = reset && hold_vld_p0;
  assign err_illegal = eval && illegal;
  assign stall       = eval && !illegal && hazard;
  assign fire        = eval && !illegal && !hazard;
  assign in_ready    = reset && (!hold_vld_p0 || fire) && (state == ST_RUN);
  assign drain_done  = reset && (state == ST_DRAIN) && (pending == '0) && !hold_vld_p0;

  assign issue_valid = fire;
  assign issue_op    = fire ? op : 4'd0;
  assign issue_rd    = fire ? rd : 4'd0;
  assign issue_rs    = fire ? rs : 4'd0;
  assign issue_rt    = fire ? rt : 4'd0;
  assign issue_imm   = fire ? hold_instr_p0[IMM_MSB:IMM_LSB] : 8'd0;

  issue_scoreboard #(.NREG(NREG)) u_sb (
    .clk         (clk),
    .reset       (reset),
    .set_en      (fire && (op != OP_NOP)),
    .set_idx     (rd),
    .clr_en      (wb_valid),
    .clr_idx     (wb_rd),
    .pending     (pending),
    .pending_eff (pending_eff)
  );

  // Mode register.
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Mode transitions follow the drain_req level.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (drain_req)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (!drain_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Hold-register occupancy: load on accept, free on issue or illegal drop.
  always_ff @(posedge clk) begin
    if (!reset)                  hold_vld_p0 <= 1'b0;
    else if (in_valid && in_ready) hold_vld_p0 <= 1'b1;
    else if (fire || err_illegal)  hold_vld_p0 <= 1'b0;
  end

  // Hold-register payload; qualified by hold_vld_p0 so it needs no reset.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) hold_instr_p0 <= in_instr;
  end

`ifdef ISSUE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (!reset)     stall_cnt_q <= '0;
    else if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
  end

  assign stall_cnt = reset ? stall_cnt_q : '0;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_issue_hazard_ctrl.sv
// Bench for issue_hazard_ctrl: directed scenarios plus randomized traffic,
// all checked against a cycle-level behavioural model of the issue rules.
module tb_issue_hazard_ctrl;

  localparam int NREG  = 8;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef ISSUE_STALL_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct {
    bit          r;
    bit          iv;
    logic [15:0] ins;
    bit          wv;
    logic [3:0]  wr;
    bit          dr;
  } stim_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, in_valid, wb_valid, drain_req;
  logic [15:0]      in_instr;
  logic [3:0]       wb_rd;
  logic             in_ready, issue_valid, stall, drain_done, err_illegal;
  logic [3:0]       issue_op, issue_rd, issue_rs, issue_rt;
  logic [7:0]       issue_imm;
  logic [CNT_W-1:0] stall_cnt;

  issue_hazard_ctrl #(.NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .drain_req(drain_req), .issue_valid(issue_valid), .issue_op(issue_op),
    .issue_rd(issue_rd), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_imm(issue_imm), .stall(stall), .drain_done(drain_done),
    .err_illegal(err_illegal), .stall_cnt(stall_cnt)
  );

  logic [34:0] act_vec;
  assign act_vec = {issue_valid, issue_op, issue_rd, issue_rs, issue_rt, issue_imm,
                    stall, err_illegal, in_ready, drain_done, stall_cnt};

  int errors = 0;
  int checks = 0;

  // Model state.
  bit          m_vld;
  logic [15:0] m_hold;
  bit          m_pend[NREG];
  bit          m_drain;
  int          m_cnt;

  // Model expectations for the current cycle.
  bit               e_iv, e_stall, e_err, e_rdy, e_dd, e_fire, e_set;
  logic [3:0]       e_op, e_rd, e_rs, e_rt;
  logic [7:0]       e_imm;
  logic [CNT_W-1:0] e_cnt;
  int               e_set_rd;
  logic [34:0]      e_vec;

  function automatic stim_t mk(bit r, bit iv, logic [15:0] ins, bit wv, logic [3:0] wr, bit dr);
    stim_t s;
    s.r = r; s.iv = iv; s.ins = ins; s.wv = wv; s.wr = wr; s.dr = dr;
    return s;
  endfunction

  task automatic model_eval();
    int op, rd, rs, rt;
    bit ill, haz, anyp;
    bit eff[NREG];
    op = int'(m_hold[15:12]); rd = int'(m_hold[11:8]);
    rs = int'(m_hold[7:4]);   rt = int'(m_hold[3:0]);
    for (int r = 0; r < NREG; r++) eff[r] = m_pend[r] && !(wb_valid && int'(wb_rd) == r);
    ill = (op > 3) || (op >= 1 && rd >= NREG) || (op >= 2 && (rs >= NREG || rt >= NREG));
    haz = 1'b0;
    if (!ill && op == 1) haz = eff[rd];
    if (!ill && op >= 2) haz = eff[rd] || eff[rs] || eff[rt];
    anyp = 1'b0;
    for (int r = 0; r < NREG; r++) anyp = anyp || m_pend[r];
    {e_iv, e_stall, e_err, e_rdy, e_dd, e_fire, e_set} = '0;
    {e_op, e_rd, e_rs, e_rt, e_imm, e_cnt} = '0;
    e_set_rd = rd;
    if (reset) begin
      e_err   = m_vld && ill;
      e_stall = m_vld && !ill && haz;
      e_fire  = m_vld && !ill && !haz;
      e_rdy   = (!m_vld || e_fire) && !m_drain;
      e_dd    = m_drain && !m_vld && !anyp;
      e_cnt   = CNT_EN ? CNT_W'(m_cnt) : '0;
      e_set   = e_fire && op != 0;
      if (e_fire) begin
        e_iv = 1'b1; e_op = 4'(op); e_rd = 4'(rd); e_rs = 4'(rs); e_rt = 4'(rt);
        e_imm = m_hold[7:0];
      end
    end
    e_vec = {e_iv, e_op, e_rd, e_rs, e_rt, e_imm, e_stall, e_err, e_rdy, e_dd, e_cnt};
  endtask

  task automatic model_commit();
    if (!reset) begin
      m_vld = 1'b0; m_drain = 1'b0; m_cnt = 0;
      for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    end else begin
      if (wb_valid && int'(wb_rd) < NREG) m_pend[wb_rd] = 1'b0;
      if (e_set) m_pend[e_set_rd] = 1'b1;
      if (in_valid && e_rdy) begin m_vld = 1'b1; m_hold = in_instr; end
      else if (e_fire || e_err) m_vld = 1'b0;
      m_drain = drain_req;
      if (e_stall && m_cnt < CMAX) m_cnt++;
    end
  endtask

  task automatic apply(input stim_t s);
    @(negedge clk);
    reset = s.r; in_valid = s.iv; in_instr = s.ins;
    wb_valid = s.wv; wb_rd = s.wr; drain_req = s.dr;
    #1;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      apply(mk(i >= 2, 1'b0, 16'($urandom), 1'b1, 4'($urandom), 1'b0));
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL reset cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      if (i == 2) begin
        checks++;
        if (in_ready !== 1'b1 || issue_valid !== 1'b0 || stall_cnt !== '0) begin
          errors++; $display("FAIL reset_release got rdy=%b iv=%b cnt=%0d exp rdy=1 iv=0 cnt=0", in_ready, issue_valid, stall_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_raw_stall();
    stim_t s[$];
    s.push_back(mk(0, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h1105, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h120A, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h2312, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 1, 4'd1, 0));
    s.push_back(mk(1, 0, 16'h0000, 1, 4'd2, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL raw_stall cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (stall !== 1'b1 || issue_valid !== 1'b0) begin
          errors++; $display("FAIL raw_stall_hold cyc%0d got stall=%b iv=%b exp stall=1 iv=0", i, stall, issue_valid);
        end
      end
      if (i == 6) begin
        checks++;
        if (issue_valid !== 1'b1 || issue_op !== 4'd2 || issue_rd !== 4'd3) begin
          errors++; $display("FAIL raw_issue got iv=%b op=%0d rd=%0d exp iv=1 op=2 rd=3", issue_valid, issue_op, issue_rd);
        end
      end
      if (i == 7) begin
        checks++;
        if (stall_cnt !== (CNT_EN ? CNT_W'(2) : '0)) begin
          errors++; $display("FAIL raw_stall_cnt got=%0d exp=%0d", stall_cnt, CNT_EN ? 2 : 0);
        end
      end
      tick();
    end
  endtask

  task automatic test_waw();
    stim_t s[$];
    s.push_back(mk(0, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h1105, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h1107, 0, 0, 0));
    for (int k = 0; k < 5; k++) s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 1, 4'd1, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL waw cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      if (i == 7) begin
        checks++;
        if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall got=%b exp=1", stall); end
      end
      if (i == 8) begin
        checks++;
        if (issue_valid !== 1'b1 || issue_imm !== 8'h07) begin
          errors++; $display("FAIL waw_issue got iv=%b imm=%h exp iv=1 imm=07", issue_valid, issue_imm);
        end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    stim_t s[$];
    int errs = 0;
    int early_issue = 0;
    s.push_back(mk(0, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h4000, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h1905, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h2010, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      if (err_illegal === 1'b1) errs++;
      if (i < 6 && issue_valid === 1'b1) early_issue++;
      if (i == 6) begin
        checks++;
        if (issue_valid !== 1'b1 || issue_op !== 4'd2) begin
          errors++; $display("FAIL illegal_sb_clean got iv=%b op=%0d exp iv=1 op=2", issue_valid, issue_op);
        end
      end
      tick();
    end
    checks++;
    if (errs != 2 || early_issue != 0) begin
      errors++; $display("FAIL illegal_pulses got err=%0d issued=%0d exp err=2 issued=0", errs, early_issue);
    end
  endtask

  task automatic test_drain();
    stim_t s[$];
    s.push_back(mk(0, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h1105, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 1));
    s.push_back(mk(1, 1, 16'h2312, 0, 0, 1));
    s.push_back(mk(1, 1, 16'h2312, 1, 4'd1, 1));
    s.push_back(mk(1, 1, 16'h2312, 0, 0, 1));
    s.push_back(mk(1, 1, 16'h2312, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h2312, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL drain cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      if (i == 3) begin
        checks++;
        if (in_ready !== 1'b0 || drain_done !== 1'b0) begin
          errors++; $display("FAIL drain_busy got rdy=%b dd=%b exp rdy=0 dd=0", in_ready, drain_done);
        end
      end
      if (i == 5) begin
        checks++;
        if (drain_done !== 1'b1) begin errors++; $display("FAIL drain_done got=%b exp=1", drain_done); end
      end
      if (i == 7) begin
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_exit_rdy got=%b exp=1", in_ready); end
      end
      if (i == 8) begin
        checks++;
        if (issue_valid !== 1'b1) begin errors++; $display("FAIL drain_resume_issue got=%b exp=1", issue_valid); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_stall();
    stim_t s[$];
    s.push_back(mk(0, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h1105, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h120A, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h2312, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(0, 0, 16'h0000, 0, 0, 0));
    s.push_back(mk(1, 1, 16'h2312, 0, 0, 0));
    s.push_back(mk(1, 0, 16'h0000, 0, 0, 0));
    foreach (s[i]) begin
      apply(s[i]);
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL rst_stall cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      if (i == 7) begin
        checks++;
        if (issue_valid !== 1'b0 || stall !== 1'b0 || stall_cnt !== '0 || in_ready !== 1'b1) begin
          errors++; $display("FAIL rst_stall_after got iv=%b st=%b cnt=%0d rdy=%b exp 0 0 0 1", issue_valid, stall, stall_cnt, in_ready);
        end
      end
      if (i == 8) begin
        checks++;
        if (issue_valid !== 1'b1) begin errors++; $display("FAIL rst_stall_sb_empty got iv=%b exp=1", issue_valid); end
      end
      tick();
    end
  endtask

  task automatic test_stall_sat();
    apply(mk(0, 0, 16'h0000, 0, 0, 0)); tick();
    apply(mk(1, 1, 16'h1105, 0, 0, 0)); tick();
    apply(mk(1, 1, 16'h1105, 0, 0, 0)); tick();
    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      apply(mk(1, 0, 16'h0000, 0, 0, 0));
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL stall_sat cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      tick();
    end
    apply(mk(1, 0, 16'h0000, 0, 0, 0));
    checks++;
    if (stall_cnt !== (CNT_EN ? CNT_W'(CMAX) : '0)) begin
      errors++; $display("FAIL stall_sat_final got=%0d exp=%0d", stall_cnt, CNT_EN ? CMAX : 0);
    end
    tick();
  endtask

  task automatic test_random();
    bit dr = 1'b0;
    apply(mk(0, 0, 16'h0000, 0, 0, 0)); tick();
    for (int i = 0; i < 800; i++) begin
      logic [15:0] ins;
      logic [3:0]  op;
      logic [3:0]  wr;
      op = ($urandom_range(0, 15) < 13) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      ins = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
      if ($urandom_range(0, 19) == 0) ins[11] = 1'b1;
      if ($urandom_range(0, 19) == 0) ins[7] = 1'b1;
      if ($urandom_range(0, 19) == 0) ins[3] = 1'b1;
      wr = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      if ($urandom_range(0, 29) == 0) dr = ~dr;
      apply(mk($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, ins,
               $urandom_range(0, 1) == 1, wr, dr));
      checks++;
      if (act_vec !== e_vec) begin
        errors++; $display("FAIL random cyc%0d got=%h exp=%h", i, act_vec, e_vec);
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0;
    wb_valid = 1'b0; wb_rd = '0; drain_req = 1'b0;
    test_reset();
    test_raw_stall();
    test_waw();
    test_illegal();
    test_drain();
    test_reset_mid_stall();
    test_stall_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
